// File: rtl/pulse_meter_if.sv
// Bundle between pulse_meter and its user: the measured input and the
// published high/low counts, strobe, timeout flag and conditioned level.
interface pulse_meter_if #(
  parameter int unsigned CNT_W = 28
);
  logic             sig_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             meas_valid;
  logic             stuck;
  logic             level;

  modport master (
    output sig_in,
    input  high_cnt, low_cnt, meas_valid, stuck, level
  );

  modport slave (
    input  sig_in,
    output high_cnt, low_cnt, meas_valid, stuck, level
  );
endinterface

// File: rtl/pulse_meter.sv
// Measures high/low durations of an asynchronous square wave in clock cycles.
// Define GLITCH_FILTER_EN to insert a FILT_LEN-sample run-length filter after the synchronizer.
module pulse_meter #(
  parameter int unsigned CNT_W    = 28,
`ifdef GLITCH_FILTER_EN
  parameter int unsigned FILT_LEN = 3,
`endif
  parameter int unsigned TIMEOUT  = 200_000_000
) (
  input logic          CLK100MHZ,
  input logic          RST,
  pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS_HIGH, MEAS_LOW} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  logic [1:0]       sync_q, sync_d;
  logic             s;
  logic             p_q, p_d;
  logic             rise, fall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_q, stuck_d;

  assign sync_d = {sync_q[0], bus.sig_in};

`ifdef GLITCH_FILTER_EN
  localparam int unsigned      FW        = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);

  logic          s_q, s_d;
  logic [FW-1:0] filt_q, filt_d;

  // s follows the synchronizer only after FILT_LEN consecutive differing samples
  always_comb begin
    s_d    = s_q;
    filt_d = '0;
    if (sync_q[1] != s_q) begin
      if (filt_q == FILT_LAST) begin
        s_d = sync_q[1];
      end else begin
        filt_d = filt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      s_q    <= 1'b0;
      filt_q <= '0;
    end else begin
      s_q    <= s_d;
      filt_q <= filt_d;
    end
  end

  assign s = s_q;
`else
  assign s = sync_q[1];
`endif

  assign p_d  = s;
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  // Edge-restarted counter and period FSM; an edge always beats the timeout
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_ONE;
    hi_lat_d     = hi_lat_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    meas_valid_d = 1'b0;
    stuck_d      = stuck_q;
    if (rise || fall) begin
      cnt_d = CNT_ONE;
      unique case (state_q)
        IDLE:      if (fall) state_d = ARM;
        ARM:       if (rise) state_d = MEAS_HIGH;
        MEAS_HIGH: if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = MEAS_LOW;
        end
        MEAS_LOW:  if (rise) begin
          high_cnt_d   = hi_lat_q;
          low_cnt_d    = cnt_q;
          meas_valid_d = 1'b1;
          stuck_d      = 1'b0;
          state_d      = MEAS_HIGH;
        end
        default:   state_d = IDLE;
      endcase
    end else if (cnt_q == CNT_TO) begin
      stuck_d = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sync_q       <= '0;
      p_q          <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_lat_q     <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      meas_valid_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      p_q          <= p_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_lat_q     <= hi_lat_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      meas_valid_q <= meas_valid_d;
      stuck_q      <= stuck_d;
    end
  end

  assign bus.high_cnt   = high_cnt_q;
  assign bus.low_cnt    = low_cnt_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.stuck      = stuck_q;
  assign bus.level      = s;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: expected high/low pairs are queued as each
// period is driven and compared when meas_valid strobes.
module tb_pulse_meter;

  localparam int unsigned CNT_W   = 28;
  localparam int unsigned TIMEOUT = 20;
`ifdef GLITCH_FILTER_EN
  localparam int unsigned SYNC_LAT = 5;
`else
  localparam int unsigned SYNC_LAT = 2;
`endif

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int unsigned gap = 0;
  exp_t sb[$];

  pulse_meter_if #(.CNT_W(CNT_W)) bus ();

  pulse_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK100MHZ(clk),
    .RST      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued period
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      exp_t e;
      gap      = cyc - last_cyc;
      last_cyc = cyc;
      e = (sb.size() != 0) ? sb.pop_front() : '1;
      check("strobe_high", 64'(bus.high_cnt), 64'(e.hi));
      check("strobe_low", 64'(bus.low_cnt), 64'(e.lo));
      check("strobe_stuck_clear", 64'(bus.stuck), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    bus.sig_in = v;
    repeat (n) tick();
  endtask

  task automatic push(input int h, input int l);
    exp_t e;
    e.hi = CNT_W'(h);
    e.lo = CNT_W'(l);
    sb.push_back(e);
  endtask

  task automatic stream(input int h, input int l, input int n, input int skip);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, h);
      hold(1'b0, l);
      if (i >= skip) push(h, l);
    end
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    bus.sig_in = lvl;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    bus.sig_in = 1'b0;

    // reset held with a toggling input
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.sig_in = ~bus.sig_in;
      tick();
      check("reset_outputs", 64'({bus.high_cnt, bus.low_cnt, bus.meas_valid, bus.stuck, bus.level}), 64'(0));
    end
    rst = 1'b0;
    bus.sig_in = 1'b0;
    repeat (4) tick();
    check("post_reset_outputs", 64'({bus.high_cnt, bus.low_cnt, bus.meas_valid, bus.stuck, bus.level}), 64'(0));

    // periodic 4/6 with latency and spacing
    do_reset(1'b0);
    stream(4, 6, 4, 1);
    bus.sig_in = 1'b1;
    repeat (SYNC_LAT) tick();
    check("latency_before", 64'(bus.meas_valid), 64'(0));
    tick();
    check("latency_strobe", 64'(bus.meas_valid), 64'(1));
    hold(1'b1, 3);
    drain("drain_4_6");
    check("strobe_gap", 64'(gap), 64'(10));
    check("hold_high", 64'(bus.high_cnt), 64'(4));
    check("hold_low", 64'(bus.low_cnt), 64'(6));
    check("level_high", 64'(bus.level), 64'(1));

    // input high at reset release, 7/3 afterwards
    do_reset(1'b1);
    hold(1'b1, 5);
    hold(1'b0, 3);
    stream(7, 3, 3, 0);
    hold(1'b1, 8);
    drain("drain_7_3");
    check("hold_high_7", 64'(bus.high_cnt), 64'(7));
    check("hold_low_3", 64'(bus.low_cnt), 64'(3));

    // timeout on a stalled high input, then recovery
    do_reset(1'b0);
    stream(5, 5, 3, 1);
    bus.sig_in = 1'b1;
    repeat (SYNC_LAT + TIMEOUT) tick();
    check("stuck_early", 64'(bus.stuck), 64'(0));
    tick();
    check("stuck_set", 64'(bus.stuck), 64'(1));
    check("stuck_keeps_high", 64'(bus.high_cnt), 64'(5));
    check("stuck_keeps_low", 64'(bus.low_cnt), 64'(5));
    check("stuck_no_pending", 64'(sb.size()), 64'(0));
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);
    push(5, 5);
    check("stuck_sticky", 64'(bus.stuck), 64'(1));
    hold(1'b1, 8);
    drain("drain_recover");
    check("stuck_cleared", 64'(bus.stuck), 64'(0));

    // reset in the middle of a low phase
    do_reset(1'b0);
    stream(4, 6, 3, 1);
    hold(1'b1, 4);
    hold(1'b0, SYNC_LAT + 2);
    check("pre_rst_drained", 64'(sb.size()), 64'(0));
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    stream(4, 6, 3, 1);
    hold(1'b1, 8);
    drain("drain_after_rst");
    check("rst_resume_high", 64'(bus.high_cnt), 64'(4));
    check("rst_resume_low", 64'(bus.low_cnt), 64'(6));

    // one-cycle low glitch inside a high phase
    do_reset(1'b0);
    stream(4, 6, 2, 1);
    hold(1'b1, 3);
    hold(1'b0, 1);
`ifndef GLITCH_FILTER_EN
    push(3, 1);
`endif
    hold(1'b1, 1);
    hold(1'b0, 6);
`ifdef GLITCH_FILTER_EN
    push(5, 6);
`else
    push(1, 6);
`endif
    stream(4, 6, 2, 0);
    hold(1'b1, 8);
    drain("drain_glitch");
    check("glitch_tail_high", 64'(bus.high_cnt), 64'(4));
    check("glitch_tail_low", 64'(bus.low_cnt), 64'(6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
